// File: rtl/clkout_fwd_if.sv
// clkout_fwd request/status bundle.
// The slave side is the clock generator, the master side is its controller.
interface clkout_fwd_if #(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] div_value;
    logic                 div_load;
    logic                 clkout;
    logic                 clkout_rise;
    logic                 div_ack;
    logic                 div_pending;
    logic                 running;
    logic [CNT_WIDTH-1:0] rise_count;

    modport master (
        output enable, div_value, div_load,
        input  clkout, clkout_rise, div_ack,
        input  div_pending, running, rise_count
    );

    modport slave (
        input  enable, div_value, div_load,
        output clkout, clkout_rise, div_ack,
        output div_pending, running, rise_count
    );
endinterface

// File: rtl/clkout_fwd.sv
// Programmable glitch-free forwarded clock generator.
// Divide changes and start/stop take effect only at period boundaries.
module clkout_fwd #(
    parameter int DIV_WIDTH = 8,
    parameter int DIV_RESET = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic         usb_clk,
    input  logic         reset_n,
    clkout_fwd_if.slave  bus
);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 clkout_q, clkout_d;
    logic                 rise_q, rise_d;
    logic                 ack_q, ack_d;
    logic                 pending_q, pending_d;
    logic                 running_q, running_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] half_cnt_q, half_cnt_d;
    logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
    logic [DIV_WIDTH-1:0] div_next_q, div_next_d;

    // Next-state: phase counting, boundary-aligned divide swap and start/stop.
    always_comb begin
        state_d      = state_q;
        clkout_d     = clkout_q;
        rise_d       = 1'b0;
        ack_d        = 1'b0;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        half_cnt_d   = half_cnt_q;
        div_active_d = div_active_q;
        div_next_d   = div_next_q;

        unique case (state_q)
            IDLE: begin
                clkout_d   = 1'b0;
                half_cnt_d = '0;
                if (pending_q) begin
                    div_active_d = div_next_q;
                    ack_d        = 1'b1;
                    pending_d    = 1'b0;
                end
                if (bus.enable) begin
                    state_d  = RUN;
                    clkout_d = 1'b1;
                    rise_d   = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            RUN, STOP_PEND: begin
                state_d = bus.enable ? RUN : STOP_PEND;
                if (half_cnt_q == div_active_q) begin
                    half_cnt_d = '0;
                    if (clkout_q) begin
                        clkout_d = 1'b0;
                    end else begin
                        if (pending_q) begin
                            div_active_d = div_next_q;
                            ack_d        = 1'b1;
                            pending_d    = 1'b0;
                        end
                        if (bus.enable) begin
                            clkout_d = 1'b1;
                            rise_d   = 1'b1;
                            cnt_d    = cnt_q + 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                clkout_d = 1'b0;
            end
        endcase

        // A load always wins over the clear of an apply in the same cycle.
        if (bus.div_load) begin
            div_next_d = bus.div_value;
            pending_d  = 1'b1;
        end

        running_d = (state_d != IDLE);
    end

    // State and registered outputs; reset forces clkout low at once.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clkout_q     <= 1'b0;
            rise_q       <= 1'b0;
            ack_q        <= 1'b0;
            pending_q    <= 1'b0;
            running_q    <= 1'b0;
            cnt_q        <= '0;
            half_cnt_q   <= '0;
            div_active_q <= DIV_RST;
            div_next_q   <= DIV_RST;
        end else begin
            state_q      <= state_d;
            clkout_q     <= clkout_d;
            rise_q       <= rise_d;
            ack_q        <= ack_d;
            pending_q    <= pending_d;
            running_q    <= running_d;
            cnt_q        <= cnt_d;
            half_cnt_q   <= half_cnt_d;
            div_active_q <= div_active_d;
            div_next_q   <= div_next_d;
        end
    end

    assign bus.clkout      = clkout_q;
    assign bus.clkout_rise = rise_q;
    assign bus.div_ack     = ack_q;
    assign bus.div_pending = pending_q;
    assign bus.running     = running_q;
    assign bus.rise_count  = cnt_q;
endmodule

// File: doc/clkout_fwd.md
# clkout_fwd

Programmable forwarded-clock generator for the Artix target. It takes the buffered USB clock and produces a divided, glitch-free clock output (`clkout`) for the capture hardware and the crypto core. Divide ratio changes and start/stop requests are applied only at period boundaries. It sits downstream of the input clock buffering and is the outgoing counterpart to it: it creates and drives a clock rather than receiving one.

## Interface
Parameters:
- `DIV_WIDTH`, 8: width of the divide value.
- `DIV_RESET`, 1: active divide value after reset; gives usb_clk/4.
- `CNT_WIDTH`, 16: width of the rising-edge counter.

Ports:
- `usb_clk`, in, 1: sole clock; all logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: level request to run `clkout`.
- `div_value`, in, DIV_WIDTH: requested half-period minus 1. Output period = 2*(div_value+1) usb_clk cycles.
- `div_load`, in, 1: single-cycle strobe that captures `div_value` into the pending register.
- `clkout`, out, 1: forwarded clock, driven directly from a flop.
- `clkout_rise`, out, 1: one-cycle strobe in the cycle `clkout` goes 0→1.
- `div_ack`, out, 1: one-cycle strobe when the pending value becomes active.
- `div_pending`, out, 1: high while a loaded value waits for a boundary.
- `running`, out, 1: high in RUN and STOP_PEND.
- `rise_count`, out, CNT_WIDTH: count of `clkout` rising edges since reset. Wraps from all-ones to 0.

## Operation
- Internal state:
  - `div_active` and `div_next` (both DIV_WIDTH).
  - `half_cnt` (DIV_WIDTH).
  - FSM with states IDLE, RUN, STOP_PEND.
- Reset values: `clkout`=0, `clkout_rise`=0, `div_ack`=0, `div_pending`=0, `running`=0, `rise_count`=0, `half_cnt`=0, `div_active`=`div_next`=DIV_RESET, state IDLE.
- `div_load` writes `div_next` and sets `div_pending`.
  - A second load before the value is applied overwrites `div_next`; the latest value wins and only one `div_ack` is issued.
- IDLE:
  - `clkout` is held at 0.
  - If `div_pending`, move `div_next` into `div_active`, pulse `div_ack`, and clear `div_pending`.
  - If `enable` is sampled high: go to RUN, drive `clkout` to 1 on the same edge, pulse `clkout_rise`, increment `rise_count`, and clear `half_cnt`.
  - If `enable` and a pending load arrive in the same IDLE cycle, the new value is active for the first high phase.
- RUN:
  - `half_cnt` increments each cycle.
  - When `half_cnt` == `div_active`, toggle `clkout` and clear `half_cnt`.
  - At the end of a low phase (the toggle 0→1):
    - Apply any pending divide value first: update `div_active`, pulse `div_ack`.
    - Then, if `enable`=0, go to IDLE and leave `clkout` at 0; no rise occurs.
    - Otherwise rise normally, with `clkout_rise` and a `rise_count` increment.
  - If `enable` is sampled low in any cycle, go to STOP_PEND.
- STOP_PEND:
  - Completes the current high phase (if any) and the full low phase.
  - Then goes to IDLE.
  - If `enable` returns high before the low phase ends, go back to RUN with no disruption to `clkout`.
- `clkout` never produces a phase shorter than `div_active`+1 cycles. A divide change never truncates or extends a phase that is already in progress.
- `div_value`=0 gives usb_clk/2.

## Timing
- Start latency: `enable` sampled high at edge N in IDLE → `clkout`=1 after edge N. High phase lasts `div_active`+1 cycles.
- Stop latency: `clkout` ends low after the current period completes. Worst case is 2*(`div_active`+1) cycles after `enable` falls.
- `div_ack` is asserted in the same cycle that `clkout` rises with the new ratio, or in the cycle after the load when in IDLE.
- `clkout_rise` and `rise_count` update in the same cycle as the `clkout` 0→1 edge.
- Asynchronous reset mid-operation: `clkout` goes to 0 immediately and all state returns to the reset values. The pending load is discarded.

## Test plan
- After reset, `enable`=1 with DIV_RESET=1 → `clkout` is 1,1,0,0 repeating (period 4), starting on the cycle after `enable` is sampled. `rise_count` is 3 after 12 cycles.
- Running with div=1, load `div_value`=3 mid-high phase → current high and low phases are 2 cycles each. `div_ack` pulses at the next rise, after which the period is 8 with a 4/4 duty.
- Two loads (5 then 2) within one period → a single `div_ack`, and the final half-period is 3 cycles.
- `enable` dropped 1 cycle into the high phase (div=3) → high lasts 4 cycles, low lasts 4 cycles, then IDLE. `running`=0 and no further `clkout_rise`.
- `enable` toggled 1→0→1 within one low phase → `clkout` waveform is identical to keeping `enable` continuously high.
- `reset_n` asserted while `clkout`=1 with a pending load → `clkout`=0 asynchronously, `rise_count`=0, `div_pending`=0, and after release the period is 4 again.
